// File: rtl/alu_issue_stage_pkg.sv
// alu_issue_stage_pkg
//   Shared encodings for the ALU issue stage: operand-select codes,
//   issue-register state encoding and the EXU ALU opcodes.
package alu_issue_stage_pkg;

  // Operand select codes. Both sources share the same numbering:
  // 0 = register, 1 = alternate (pc / imm), 2 = constant, 3 = reserved.
  localparam logic [1:0] SEL_RS    = 2'd0;
  localparam logic [1:0] SEL_ALT   = 2'd1;
  localparam logic [1:0] SEL_CONST = 2'd2;

  localparam logic [1:0] SRC1_SEL_RS1  = SEL_RS;
  localparam logic [1:0] SRC1_SEL_PC   = SEL_ALT;
  localparam logic [1:0] SRC1_SEL_ZERO = SEL_CONST;

  localparam logic [1:0] SRC2_SEL_RS2  = SEL_RS;
  localparam logic [1:0] SRC2_SEL_IMM  = SEL_ALT;
  localparam logic [1:0] SRC2_SEL_FOUR = SEL_CONST;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } issue_state_t;

  localparam logic [3:0] OPT_EXU_ADD  = 4'd0;
  localparam logic [3:0] OPT_EXU_SUB  = 4'd1;
  localparam logic [3:0] OPT_EXU_AND  = 4'd2;
  localparam logic [3:0] OPT_EXU_OR   = 4'd3;
  localparam logic [3:0] OPT_EXU_XOR  = 4'd4;
  localparam logic [3:0] OPT_EXU_SLL  = 4'd5;
  localparam logic [3:0] OPT_EXU_SRL  = 4'd6;
  localparam logic [3:0] OPT_EXU_SRA  = 4'd7;
  localparam logic [3:0] OPT_EXU_SLT  = 4'd8;

  // Write-back bypass applies only to a live, non-x0 destination that
  // matches the source index.
  function automatic logic fwd_hit(input logic fwd_valid,
                                   input logic [4:0] fwd_rd,
                                   input logic [4:0] rs_idx);
    return fwd_valid && (fwd_rd != 5'd0) && (fwd_rd == rs_idx);
  endfunction

endpackage

// File: rtl/alu_issue_stage_operand_sel.sv
// alu_issue_stage_operand_sel
//   Combinational operand select with write-back forwarding for one source.
//   Ports:
//     sel        operand select code (register / alternate / constant)
//     rs_idx     source register index
//     rs_data    register-file read data
//     alt_data   pc for src1, immediate for src2
//     fwd_*      write-back forwarding port
//     operand    selected operand
//   IS_SRC2 chooses the constant: 4 for src2, zero for src1.
module alu_issue_stage_operand_sel
  import alu_issue_stage_pkg::*;
#(
  parameter int ISA_WIDTH = 32,
  parameter bit IS_SRC2   = 1'b0
) (
  input  logic [1:0]           sel,
  input  logic [4:0]           rs_idx,
  input  logic [ISA_WIDTH-1:0] rs_data,
  input  logic [ISA_WIDTH-1:0] alt_data,
  input  logic                 fwd_valid,
  input  logic [4:0]           fwd_rd,
  input  logic [ISA_WIDTH-1:0] fwd_data,
  output logic [ISA_WIDTH-1:0] operand
);

  localparam logic [ISA_WIDTH-1:0] CONST_VAL =
    IS_SRC2 ? {{(ISA_WIDTH-3){1'b0}}, 3'b100} : {ISA_WIDTH{1'b0}};

  always_comb begin
    operand = '0;
    case (sel)
      SEL_RS:    operand = fwd_hit(fwd_valid, fwd_rd, rs_idx) ? fwd_data : rs_data;
      SEL_ALT:   operand = alt_data;
      SEL_CONST: operand = CONST_VAL;
      default:   operand = '0;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage
//   Decode-to-execute issue register. Captures decoded instructions from the
//   IDU, selects and forwards ALU operands at capture, and presents them to
//   the EXU from a registered main entry backed by a one-deep skid entry.
//   Ports:
//     clock, rst_n             clock, async active-low reset
//     in_valid / in_ready      IDU handshake (in_ready is a flop)
//     in_rs*_idx, in_rs*_data  source indices and register-file data
//     in_pc, in_imm            alternate operands
//     in_src1_sel, in_src2_sel operand select codes
//     in_opt, in_if_unsigned, in_rd, in_wen   pass-through fields
//     fwd_valid, fwd_rd, fwd_data             write-back forwarding
//     flush                    drop every held instruction
//     out_valid / out_ready    EXU handshake
//     out_*                    registered operands and pass-through fields
//
//   state | meaning
//   EMPTY | nothing held, outputs hold last loaded values
//   ONE   | main entry valid, skid empty
//   TWO   | main and skid both valid, input stalled
module alu_issue_stage
  import alu_issue_stage_pkg::*;
#(
  parameter int ISA_WIDTH = 32,
  parameter int OPT_WIDTH = 4
) (
  input  logic                 clock,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4:0]           in_rs1_idx,
  input  logic [4:0]           in_rs2_idx,
  input  logic [ISA_WIDTH-1:0] in_rs1_data,
  input  logic [ISA_WIDTH-1:0] in_rs2_data,
  input  logic [ISA_WIDTH-1:0] in_pc,
  input  logic [ISA_WIDTH-1:0] in_imm,
  input  logic [1:0]           in_src1_sel,
  input  logic [1:0]           in_src2_sel,
  input  logic [OPT_WIDTH-1:0] in_opt,
  input  logic                 in_if_unsigned,
  input  logic [4:0]           in_rd,
  input  logic                 in_wen,
  input  logic                 fwd_valid,
  input  logic [4:0]           fwd_rd,
  input  logic [ISA_WIDTH-1:0] fwd_data,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ISA_WIDTH-1:0] out_src1,
  output logic [ISA_WIDTH-1:0] out_src2,
  output logic [OPT_WIDTH-1:0] out_opt,
  output logic                 out_if_unsigned,
  output logic [4:0]           out_rd,
  output logic                 out_wen
);

  issue_state_t state;

  logic [ISA_WIDTH-1:0] new_src1;
  logic [ISA_WIDTH-1:0] new_src2;

  logic [ISA_WIDTH-1:0] skid_src1;
  logic [ISA_WIDTH-1:0] skid_src2;
  logic [OPT_WIDTH-1:0] skid_opt;
  logic                 skid_if_unsigned;
  logic [4:0]           skid_rd;
  logic                 skid_wen;

  logic in_fire;
  logic out_fire;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  alu_issue_stage_operand_sel #(
    .ISA_WIDTH (ISA_WIDTH),
    .IS_SRC2   (1'b0)
  ) u_sel_src1 (
    .sel       (in_src1_sel),
    .rs_idx    (in_rs1_idx),
    .rs_data   (in_rs1_data),
    .alt_data  (in_pc),
    .fwd_valid (fwd_valid),
    .fwd_rd    (fwd_rd),
    .fwd_data  (fwd_data),
    .operand   (new_src1)
  );

  alu_issue_stage_operand_sel #(
    .ISA_WIDTH (ISA_WIDTH),
    .IS_SRC2   (1'b1)
  ) u_sel_src2 (
    .sel       (in_src2_sel),
    .rs_idx    (in_rs2_idx),
    .rs_data   (in_rs2_data),
    .alt_data  (in_imm),
    .fwd_valid (fwd_valid),
    .fwd_rd    (fwd_rd),
    .fwd_data  (fwd_data),
    .operand   (new_src2)
  );

  // out_valid and in_ready are kept as their own flops so neither output has
  // a combinational path from out_ready or from the state decode.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state            <= ST_EMPTY;
      out_valid        <= 1'b0;
      in_ready         <= 1'b1;
      out_src1         <= '0;
      out_src2         <= '0;
      out_opt          <= '0;
      out_if_unsigned  <= 1'b0;
      out_rd           <= '0;
      out_wen          <= 1'b0;
      skid_src1        <= '0;
      skid_src2        <= '0;
      skid_opt         <= '0;
      skid_if_unsigned <= 1'b0;
      skid_rd          <= '0;
      skid_wen         <= 1'b0;
    end else if (flush) begin
      // Main entry data is left untouched so outputs hold while invalid.
      state     <= ST_EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (in_fire) begin
            out_src1        <= new_src1;
            out_src2        <= new_src2;
            out_opt         <= in_opt;
            out_if_unsigned <= in_if_unsigned;
            out_rd          <= in_rd;
            out_wen         <= in_wen;
            state           <= ST_ONE;
            out_valid       <= 1'b1;
            in_ready        <= 1'b1;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            out_src1        <= new_src1;
            out_src2        <= new_src2;
            out_opt         <= in_opt;
            out_if_unsigned <= in_if_unsigned;
            out_rd          <= in_rd;
            out_wen         <= in_wen;
          end else if (out_fire) begin
            state     <= ST_EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end else if (in_fire) begin
            skid_src1        <= new_src1;
            skid_src2        <= new_src2;
            skid_opt         <= in_opt;
            skid_if_unsigned <= in_if_unsigned;
            skid_rd          <= in_rd;
            skid_wen         <= in_wen;
            state            <= ST_TWO;
            in_ready         <= 1'b0;
          end
        end
        ST_TWO: begin
          if (out_fire) begin
            out_src1        <= skid_src1;
            out_src2        <= skid_src2;
            out_opt         <= skid_opt;
            out_if_unsigned <= skid_if_unsigned;
            out_rd          <= skid_rd;
            out_wen         <= skid_wen;
            state           <= ST_ONE;
            in_ready        <= 1'b1;
          end
        end
        default: begin
          state     <= ST_EMPTY;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;
  import alu_issue_stage_pkg::*;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_rs1_idx = '0, in_rs2_idx = '0;
  logic [31:0] in_rs1_data = '0, in_rs2_data = '0, in_pc = '0, in_imm = '0;
  logic [1:0]  in_src1_sel = '0, in_src2_sel = '0;
  logic [3:0]  in_opt = '0;
  logic        in_if_unsigned = 1'b0;
  logic [4:0]  in_rd = '0;
  logic        in_wen = 1'b0;
  logic        fwd_valid = 1'b0;
  logic [4:0]  fwd_rd = '0;
  logic [31:0] fwd_data = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_src1, out_src2;
  logic [3:0]  out_opt;
  logic        out_if_unsigned;
  logic [4:0]  out_rd;
  logic        out_wen;

  alu_issue_stage #(.ISA_WIDTH(32), .OPT_WIDTH(4)) dut (
    .clock(clock), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1_idx(in_rs1_idx), .in_rs2_idx(in_rs2_idx),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .in_pc(in_pc), .in_imm(in_imm),
    .in_src1_sel(in_src1_sel), .in_src2_sel(in_src2_sel),
    .in_opt(in_opt), .in_if_unsigned(in_if_unsigned),
    .in_rd(in_rd), .in_wen(in_wen),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_src1(out_src1), .out_src2(out_src2), .out_opt(out_opt),
    .out_if_unsigned(out_if_unsigned), .out_rd(out_rd), .out_wen(out_wen)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] s1;
    logic [31:0] s2;
    logic [3:0]  opt;
    logic        u;
    logic [4:0]  rd;
    logic        wen;
  } item_t;

  item_t q[$];
  item_t last_head;
  item_t dut_item;
  int    n_checks = 0;
  int    n_pass = 0;
  logic  check_en = 1'b0;

  assign dut_item = '{s1: out_src1, s2: out_src2, opt: out_opt, u: out_if_unsigned,
                      rd: out_rd, wen: out_wen};

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  // What the EXU must eventually see for the instruction currently offered.
  function automatic item_t expect_item();
    item_t it;
    it = '0;
    if (in_src1_sel == 2'd0)
      it.s1 = (fwd_valid && fwd_rd != 0 && fwd_rd == in_rs1_idx) ? fwd_data : in_rs1_data;
    else if (in_src1_sel == 2'd1) it.s1 = in_pc;
    else it.s1 = 32'd0;
    if (in_src2_sel == 2'd0)
      it.s2 = (fwd_valid && fwd_rd != 0 && fwd_rd == in_rs2_idx) ? fwd_data : in_rs2_data;
    else if (in_src2_sel == 2'd1) it.s2 = in_imm;
    else if (in_src2_sel == 2'd2) it.s2 = 32'd4;
    else it.s2 = 32'd0;
    it.opt = in_opt;
    it.u   = in_if_unsigned;
    it.rd  = in_rd;
    it.wen = in_wen;
    return it;
  endfunction

  // Model: an ordered queue of at most two held instructions.
  always @(posedge clock or negedge rst_n) begin
    bit room;
    if (!rst_n) begin
      q.delete();
      last_head = '0;
    end else begin
      room = (q.size() < 2);
      if (flush) q.delete();
      else begin
        if (q.size() > 0 && out_ready) void'(q.pop_front());
        if (in_valid && room) q.push_back(expect_item());
      end
      if (q.size() > 0) last_head = q[0];
    end
  end

  always @(negedge clock) begin
    if (rst_n && check_en) begin
      chk("model_out_valid", 128'(out_valid), 128'(q.size() > 0));
      chk("model_in_ready", 128'(in_ready), 128'(q.size() < 2));
      chk("model_payload", 128'(dut_item), 128'((q.size() > 0) ? q[0] : last_head));
    end
  end

  task automatic drive(input logic [4:0] r1i, input logic [31:0] r1d,
                       input logic [4:0] r2i, input logic [31:0] r2d,
                       input logic [31:0] pc, input logic [31:0] imm,
                       input logic [1:0] s1, input logic [1:0] s2,
                       input logic [3:0] opt, input logic u,
                       input logic [4:0] rd, input logic wen);
    in_valid = 1'b1;
    in_rs1_idx = r1i; in_rs1_data = r1d; in_rs2_idx = r2i; in_rs2_data = r2d;
    in_pc = pc; in_imm = imm; in_src1_sel = s1; in_src2_sel = s2;
    in_opt = opt; in_if_unsigned = u; in_rd = rd; in_wen = wen;
  endtask

  // Returns at the falling edge after the accepting rising edge.
  task automatic wait_accept(input string name, output int cycles);
    bit ok;
    ok = 1'b0;
    cycles = 0;
    while (!ok && cycles < 50) begin
      ok = in_ready;
      @(negedge clock);
      cycles++;
    end
    if (!ok) begin
      n_checks++;
      $display("FAIL %s: not accepted within 50 cycles", name);
    end
  endtask

  initial begin
    int cyc;
    repeat (3) @(negedge clock);
    chk("reset_out_valid", 128'(out_valid), 128'(0));
    chk("reset_in_ready", 128'(in_ready), 128'(1));
    chk("reset_payload", 128'(dut_item), 128'(0));
    rst_n = 1'b1;
    check_en = 1'b1;
    @(negedge clock);

    // single issue
    out_ready = 1'b1;
    drive(5'd5, 32'h10, 5'd0, 32'h0, 32'h100, 32'hFFFF_FFF0, SRC1_SEL_RS1, SRC2_SEL_IMM,
          OPT_EXU_ADD, 1'b0, 5'd7, 1'b1);
    wait_accept("single", cyc);
    in_valid = 1'b0;
    chk("single_valid", 128'(out_valid), 128'(1));
    chk("single_src1", 128'(out_src1), 128'(32'h10));
    chk("single_src2", 128'(out_src2), 128'(32'hFFFF_FFF0));
    chk("single_opt", 128'(out_opt), 128'(OPT_EXU_ADD));
    @(negedge clock);

    // forwarding
    drive(5'd3, 32'h1, 5'd0, 32'h0, 32'h0, 32'h20, SRC1_SEL_RS1, SRC2_SEL_IMM,
          OPT_EXU_SUB, 1'b1, 5'd4, 1'b1);
    fwd_valid = 1'b1; fwd_rd = 5'd3; fwd_data = 32'hABCD;
    wait_accept("fwd_hit", cyc);
    in_valid = 1'b0; fwd_valid = 1'b0;
    chk("fwd_hit_src1", 128'(out_src1), 128'(32'hABCD));
    chk("fwd_hit_unsigned", 128'(out_if_unsigned), 128'(1));
    drive(5'd0, 32'h77, 5'd2, 32'h55, 32'h0, 32'h0, SRC1_SEL_RS1, SRC2_SEL_RS2,
          OPT_EXU_OR, 1'b0, 5'd1, 1'b0);
    fwd_valid = 1'b1; fwd_rd = 5'd0; fwd_data = 32'hDEAD;
    wait_accept("fwd_x0", cyc);
    in_valid = 1'b0; fwd_valid = 1'b0;
    chk("fwd_x0_src1", 128'(out_src1), 128'(32'h77));
    chk("fwd_x0_src2", 128'(out_src2), 128'(32'h55));
    drive(5'd0, 32'h0, 5'd9, 32'h1, 32'h0, 32'h66, SRC1_SEL_ZERO, SRC2_SEL_IMM,
          OPT_EXU_AND, 1'b0, 5'd2, 1'b1);
    fwd_valid = 1'b1; fwd_rd = 5'd9; fwd_data = 32'h1234;
    wait_accept("fwd_notrs", cyc);
    in_valid = 1'b0; fwd_valid = 1'b0;
    chk("fwd_notrs_src2", 128'(out_src2), 128'(32'h66));
    @(negedge clock);

    // back-pressure A, B, C
    out_ready = 1'b0;
    drive(5'd1, 32'hA, 5'd0, 32'h0, 32'h0, 32'h0, SRC1_SEL_RS1, SRC2_SEL_RS2,
          OPT_EXU_XOR, 1'b0, 5'd10, 1'b1);
    wait_accept("bp_A", cyc);
    drive(5'd1, 32'hB, 5'd0, 32'h0, 32'h0, 32'h0, SRC1_SEL_RS1, SRC2_SEL_RS2,
          OPT_EXU_XOR, 1'b0, 5'd11, 1'b1);
    wait_accept("bp_B", cyc);
    chk("bp_in_ready_after_B", 128'(in_ready), 128'(0));
    chk("bp_head_A", 128'(out_src1), 128'(32'hA));
    drive(5'd1, 32'hC, 5'd0, 32'h0, 32'h0, 32'h0, SRC1_SEL_RS1, SRC2_SEL_RS2,
          OPT_EXU_XOR, 1'b0, 5'd12, 1'b1);
    repeat (3) @(negedge clock);
    chk("bp_C_held", 128'(in_ready), 128'(0));
    chk("bp_head_still_A", 128'(out_rd), 128'(10));
    out_ready = 1'b1;
    wait_accept("bp_C", cyc);
    in_valid = 1'b0;
    chk("bp_head_C", 128'(out_src1), 128'(32'hC));
    repeat (2) @(negedge clock);

    // streaming 8 back-to-back
    for (int i = 0; i < 8; i++) begin
      drive(5'd0, 32'h0, 5'd0, 32'h0, 32'h1000 + 32'(4 * i), 32'h0, SRC1_SEL_PC,
            SRC2_SEL_FOUR, 4'(i), 1'b0, 5'(i), 1'b1);
      wait_accept("stream", cyc);
      chk("stream_one_cycle", 128'(cyc), 128'(1));
      chk("stream_valid", 128'(out_valid), 128'(1));
      chk("stream_src1_pc", 128'(out_src1), 128'(32'h1000 + 32'(4 * i)));
      chk("stream_src2_four", 128'(out_src2), 128'(32'd4));
    end
    in_valid = 1'b0;
    repeat (2) @(negedge clock);

    // flush in TWO with a simultaneous input
    out_ready = 1'b0;
    drive(5'd1, 32'h31, 5'd0, 32'h0, 32'h0, 32'h0, SRC1_SEL_RS1, SRC2_SEL_RS2,
          OPT_EXU_SLL, 1'b0, 5'd13, 1'b1);
    wait_accept("fl_X", cyc);
    drive(5'd1, 32'h32, 5'd0, 32'h0, 32'h0, 32'h0, SRC1_SEL_RS1, SRC2_SEL_RS2,
          OPT_EXU_SLL, 1'b0, 5'd14, 1'b1);
    wait_accept("fl_Y", cyc);
    drive(5'd1, 32'h33, 5'd0, 32'h0, 32'h0, 32'h0, SRC1_SEL_RS1, SRC2_SEL_RS2,
          OPT_EXU_SLL, 1'b0, 5'd15, 1'b1);
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0; in_valid = 1'b0;
    chk("flush2_out_valid", 128'(out_valid), 128'(0));
    chk("flush2_in_ready", 128'(in_ready), 128'(1));
    chk("flush2_hold_src1", 128'(out_src1), 128'(32'h31));
    out_ready = 1'b1;
    repeat (3) @(negedge clock);

    // flush in ONE while the input would be accepted
    out_ready = 1'b0;
    drive(5'd1, 32'h51, 5'd0, 32'h0, 32'h0, 32'h0, SRC1_SEL_RS1, SRC2_SEL_RS2,
          OPT_EXU_SRL, 1'b0, 5'd16, 1'b1);
    wait_accept("fl1_P", cyc);
    drive(5'd1, 32'h52, 5'd0, 32'h0, 32'h0, 32'h0, SRC1_SEL_RS1, SRC2_SEL_RS2,
          OPT_EXU_SRL, 1'b0, 5'd17, 1'b1);
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0; in_valid = 1'b0;
    chk("flush1_out_valid", 128'(out_valid), 128'(0));
    chk("flush1_hold_src1", 128'(out_src1), 128'(32'h51));
    out_ready = 1'b1;
    repeat (3) @(negedge clock);

    // async reset while in TWO
    out_ready = 1'b0;
    drive(5'd1, 32'h41, 5'd0, 32'h0, 32'h0, 32'h9, SRC1_SEL_RS1, SRC2_SEL_IMM,
          OPT_EXU_SRA, 1'b1, 5'd18, 1'b1);
    wait_accept("rst_R", cyc);
    drive(5'd1, 32'h42, 5'd0, 32'h0, 32'h0, 32'h9, SRC1_SEL_RS1, SRC2_SEL_IMM,
          OPT_EXU_SRA, 1'b1, 5'd19, 1'b1);
    wait_accept("rst_S", cyc);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 128'(out_valid), 128'(0));
    chk("arst_in_ready", 128'(in_ready), 128'(1));
    chk("arst_payload", 128'(dut_item), 128'(0));
    @(negedge clock);
    rst_n = 1'b1;
    @(negedge clock);
    out_ready = 1'b1;
    drive(5'd0, 32'h0, 5'd0, 32'h0, 32'h2000, 32'h0, SRC1_SEL_PC, SRC2_SEL_FOUR,
          OPT_EXU_SLT, 1'b0, 5'd20, 1'b1);
    wait_accept("post_rst", cyc);
    in_valid = 1'b0;
    chk("post_rst_src1", 128'(out_src1), 128'(32'h2000));
    repeat (3) @(negedge clock);

    check_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
